cd_cmd_bridge: RTL and testbench

- Sits between the HPS extension CD port and the Neo Geo CD drive-controller emulation.
- Downstream path: detects new HPS command packets (toggle handshake on bit 48) and buffers them in a small FIFO. Presents them to the controller with valid/ready.
- Upstream path: accepts status packets from the controller, drives the 49-bit toggle-flagged status word back toward the HPS, and enforces a minimum hold time so the HPS can poll each packet before it is replaced.

---
 rtl/cd_cmd_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_cd_cmd_bridge.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_cmd_bridge.sv
// HPS <-> Neo Geo CD controller bridge: toggle-flagged command FIFO downstream, held status word upstream.
// Optional build macro CD_CMD_CHECKSUM_EN enables inverted-nibble-sum command validation and the cmd_bad_cnt port.
module cd_cmd_bridge #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic                   clk_sys,
    input  logic                   nRESET,
    input  logic [48:0]            hps_cmd_in,
    output logic [48:0]            hps_stat_out,
    output logic                   cmd_valid,
    output logic [47:0]            cmd_data,
    input  logic                   cmd_ready,
    input  logic                   stat_valid,
    input  logic [47:0]            stat_data,
    output logic                   stat_ready,
    output logic                   cmd_overflow,
    output logic [$clog2(DEPTH):0] cmd_count
`ifdef CD_CMD_CHECKSUM_EN
    ,
    output logic [7:0]             cmd_bad_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);

    // ------------------------------------------------------------------
    // Command detect and optional payload validation
    // ------------------------------------------------------------------
    logic prev_tog_reg;
    logic new_cmd;
    logic cmd_ok;

    assign new_cmd = hps_cmd_in[48] ^ prev_tog_reg;

`ifdef CD_CMD_CHECKSUM_EN
    logic [3:0] nib [11];
    logic [3:0] nib_sum;
    logic [7:0] bad_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 11; gi++) begin : g_nib
            assign nib[gi] = hps_cmd_in[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        nib_sum = '0;
        for (int i = 0; i < 11; i++) begin
            nib_sum = nib_sum + nib[i];
        end
    end

    assign cmd_ok = (hps_cmd_in[47:44] == ~nib_sum);

    always_ff @(posedge clk_sys) begin
        if (!nRESET) begin
            bad_cnt_reg <= '0;
        end else if (new_cmd && !cmd_ok && bad_cnt_reg != 8'hFF) begin
            bad_cnt_reg <= bad_cnt_reg + 8'd1;
        end
    end

    assign cmd_bad_cnt = bad_cnt_reg;
`else
    assign cmd_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [47:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_after_pop;
    logic [CW-1:0] count_next;
    logic          cmd_valid_reg;
    logic [47:0]   cmd_data_reg;
    logic          overflow_reg;
    logic          push_req;
    logic          push_en;
    logic          pop_en;
    logic          fifo_full;
    logic          drop;

    always_comb begin
        push_req        = new_cmd & cmd_ok;
        fifo_full       = (count_reg == FULL_COUNT);
        pop_en          = cmd_valid_reg & cmd_ready;
        // A pop frees the slot the simultaneous push needs, so full+pop still accepts.
        push_en         = push_req & (~fifo_full | pop_en);
        drop            = push_req & fifo_full & ~pop_en;
        count_after_pop = count_reg - CW'(pop_en);
        count_next      = count_after_pop + CW'(push_en);
        rd_ptr_next     = rd_ptr_reg + AW'(pop_en);
    end

    always_ff @(posedge clk_sys) begin
        if (nRESET && push_en) begin
            mem[wr_ptr_reg] <= hps_cmd_in[47:0];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!nRESET) begin
            prev_tog_reg  <= hps_cmd_in[48];
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            cmd_valid_reg <= 1'b0;
            cmd_data_reg  <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            prev_tog_reg <= hps_cmd_in[48];
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            cmd_valid_reg <= (count_next != '0);
            // Head register: bypass the incoming word when it lands in an otherwise empty FIFO.
            if (count_next == '0) begin
                cmd_data_reg <= '0;
            end else if (push_en && count_after_pop == '0) begin
                cmd_data_reg <= hps_cmd_in[47:0];
            end else begin
                cmd_data_reg <= mem[rd_ptr_next];
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign cmd_valid    = cmd_valid_reg;
    assign cmd_data     = cmd_data_reg;
    assign cmd_count    = count_reg;
    assign cmd_overflow = overflow_reg;

    // ------------------------------------------------------------------
    // Status path
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } stat_state_t;

    stat_state_t   state_reg;
    stat_state_t   state_next;
    logic          stat_load;
    logic          stat_ready_c;
    logic [HW-1:0] hold_cnt_reg;
    logic [48:0]   stat_reg;

    always_comb begin
        state_next   = state_reg;
        stat_load    = 1'b0;
        stat_ready_c = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                stat_ready_c = 1'b1;
                if (stat_valid) begin
                    stat_load  = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!nRESET) begin
            state_reg    <= ST_IDLE;
            hold_cnt_reg <= '0;
            stat_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (stat_load) begin
                stat_reg     <= {~stat_reg[48], stat_data};
                hold_cnt_reg <= HOLD_LOAD;
            end else if (state_reg == ST_HOLD && hold_cnt_reg != '0) begin
                hold_cnt_reg <= hold_cnt_reg - HW'(1);
            end
        end
    end

    assign stat_ready   = stat_ready_c;
    assign hps_stat_out = stat_reg;

endmodule

// File: tb/tb_cd_cmd_bridge.sv
// Randomized bench for cd_cmd_bridge: queue-based command model and edge-count status model, plus directed checks.
module tb_cd_cmd_bridge;

    localparam int DEPTH = 4;
    localparam int HOLD  = 8;

    logic                   clk_sys = 1'b0;
    logic                   nRESET;
    logic [48:0]            hps_cmd_in;
    logic [48:0]            hps_stat_out;
    logic                   cmd_valid;
    logic [47:0]            cmd_data;
    logic                   cmd_ready;
    logic                   stat_valid;
    logic [47:0]            stat_data;
    logic                   stat_ready;
    logic                   cmd_overflow;
    logic [$clog2(DEPTH):0] cmd_count;
`ifdef CD_CMD_CHECKSUM_EN
    logic [7:0]             cmd_bad_cnt;
`endif

    cd_cmd_bridge #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk_sys      (clk_sys),
        .nRESET       (nRESET),
        .hps_cmd_in   (hps_cmd_in),
        .hps_stat_out (hps_stat_out),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .stat_valid   (stat_valid),
        .stat_data    (stat_data),
        .stat_ready   (stat_ready),
        .cmd_overflow (cmd_overflow),
        .cmd_count    (cmd_count)
`ifdef CD_CMD_CHECKSUM_EN
        ,
        .cmd_bad_cnt  (cmd_bad_cnt)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

`ifdef CD_CMD_CHECKSUM_EN
    function automatic logic [3:0] nsum(input logic [43:0] p);
        logic [3:0] s = 4'h0;
        for (int i = 0; i < 11; i++) s = s + p[i*4 +: 4];
        return s;
    endfunction
`endif

    function automatic bit csum_ok(input logic [47:0] p);
`ifdef CD_CMD_CHECKSUM_EN
        return p[47:44] == ~nsum(p[43:0]);
`else
        return (p[0] === p[0]);
`endif
    endfunction

    // Make a payload acceptable to whichever build is under test.
    function automatic logic [47:0] fix(input logic [47:0] p);
        logic [47:0] r = p;
`ifdef CD_CMD_CHECKSUM_EN
        r[47:44] = ~nsum(p[43:0]);
`endif
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [47:0] m_q[$];
    bit          m_ovf;
    logic [48:0] m_stat;
    bit          m_loaded;
    int          m_load_edge;
    int          m_edge = 0;
    bit          m_prev_tog;
    int          m_bad;
    bit          m_started = 1'b0;

    initial forever begin
        bit tog, pop, rdy_prev;
        @(posedge clk_sys);
        m_edge++;
        if (!nRESET) begin
            m_q.delete();
            m_ovf      = 1'b0;
            m_stat     = '0;
            m_loaded   = 1'b0;
            m_bad      = 0;
            m_prev_tog = hps_cmd_in[48];
        end else begin
            rdy_prev   = !m_loaded || ((m_edge - 1) >= m_load_edge + HOLD);
            tog        = (hps_cmd_in[48] != m_prev_tog);
            m_prev_tog = hps_cmd_in[48];
            pop        = (m_q.size() != 0) && cmd_ready;
            if (pop) void'(m_q.pop_front());
            if (tog) begin
                if (csum_ok(hps_cmd_in[47:0])) begin
                    if (m_q.size() < DEPTH) m_q.push_back(hps_cmd_in[47:0]);
                    else m_ovf = 1'b1;
                end else if (m_bad < 255) begin
                    m_bad++;
                end
            end
            if (rdy_prev && stat_valid) begin
                m_stat      = {~m_stat[48], stat_data};
                m_loaded    = 1'b1;
                m_load_edge = m_edge;
            end
        end
        m_started = 1'b1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        bit m_ready;
        @(negedge clk_sys);
        if (m_started) begin
            m_ready = !m_loaded || (m_edge >= m_load_edge + HOLD);
            check("cmd_valid", 64'(cmd_valid), 64'(m_q.size() != 0));
            check("cmd_count", 64'(cmd_count), 64'(m_q.size()));
            if (m_q.size() != 0) check("cmd_data", 64'(cmd_data), 64'(m_q[0]));
            check("cmd_overflow", 64'(cmd_overflow), 64'(m_ovf));
            check("hps_stat_out", 64'(hps_stat_out), 64'(m_stat));
            check("stat_ready", 64'(stat_ready), 64'(m_ready));
`ifdef CD_CMD_CHECKSUM_EN
            check("cmd_bad_cnt", 64'(cmd_bad_cnt), 64'(m_bad));
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_cmd(input logic [47:0] p);
        hps_cmd_in = {~hps_cmd_in[48], p};
        tick();
    endtask

    initial begin
        nRESET     = 1'b0;
        hps_cmd_in = {1'b1, 48'h0};
        cmd_ready  = 1'b0;
        stat_valid = 1'b0;
        stat_data  = '0;
        repeat (3) tick();
        check("rst_cmd_valid", 64'(cmd_valid), 64'(0));
        check("rst_cmd_count", 64'(cmd_count), 64'(0));
        check("rst_cmd_data", 64'(cmd_data), 64'(0));
        check("rst_overflow", 64'(cmd_overflow), 64'(0));
        check("rst_stat_out", 64'(hps_stat_out), 64'(0));
        check("rst_stat_ready", 64'(stat_ready), 64'(1));

        // Toggle high at release is not a command.
        nRESET = 1'b1;
        repeat (3) tick();
        check("release_no_push", 64'(cmd_valid), 64'(0));
        hps_cmd_in = {1'b0, fix(48'h0000_0000_0010)};
        tick();
        check("first_valid", 64'(cmd_valid), 64'(1));
        check("first_data", 64'(cmd_data), 64'(fix(48'h0000_0000_0010)));
        check("first_count", 64'(cmd_count), 64'(1));
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("first_popped", 64'(cmd_valid), 64'(0));

        // Overflow: five commands into four slots.
        for (int i = 1; i <= 5; i++) send_cmd(fix(48'(i)));
        check("ovf_count", 64'(cmd_count), 64'(4));
        check("ovf_flag", 64'(cmd_overflow), 64'(1));
        cmd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("ovf_pop_data", 64'(cmd_data), 64'(fix(48'(i))));
            tick();
        end
        cmd_ready = 1'b0;
        check("ovf_drained", 64'(cmd_valid), 64'(0));

        nRESET = 1'b0;
        tick();
        nRESET = 1'b1;
        tick();

        // Full FIFO: push and pop in the same cycle.
        for (int i = 0; i < 4; i++) send_cmd(fix(48'h0A + 48'(i)));
        check("full_count", 64'(cmd_count), 64'(4));
        cmd_ready  = 1'b1;
        hps_cmd_in = {~hps_cmd_in[48], fix(48'h0E)};
        tick();
        cmd_ready = 1'b0;
        check("full_pp_count", 64'(cmd_count), 64'(4));
        check("full_pp_ovf", 64'(cmd_overflow), 64'(0));
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("full_pp_data", 64'(cmd_data), 64'(fix(48'h0B + 48'(i))));
            tick();
        end
        cmd_ready = 1'b0;
        check("full_pp_drained", 64'(cmd_valid), 64'(0));

        // Status hold window.
        stat_data  = 48'hABCD_EF01_2345;
        stat_valid = 1'b1;
        tick();
        check("stat_first", 64'(hps_stat_out), 64'(49'h1_ABCD_EF01_2345));
        check("stat_busy", 64'(stat_ready), 64'(0));
        for (int i = 0; i < 7; i++) begin
            tick();
            check("stat_busy", 64'(stat_ready), 64'(0));
        end
        tick();
        check("stat_ready_again", 64'(stat_ready), 64'(1));
        check("stat_stable", 64'(hps_stat_out), 64'(49'h1_ABCD_EF01_2345));
        tick();
        check("stat_second", 64'(hps_stat_out), 64'(49'h0_ABCD_EF01_2345));
        stat_valid = 1'b0;

        // Reset mid-hold with three queued commands.
        for (int i = 0; i < 3; i++) send_cmd(fix(48'h100 + 48'(i)));
        check("mid_count", 64'(cmd_count), 64'(3));
        nRESET     = 1'b0;
        stat_valid = 1'b1;
        tick();
        check("midrst_stat", 64'(hps_stat_out), 64'(0));
        check("midrst_ready", 64'(stat_ready), 64'(1));
        check("midrst_count", 64'(cmd_count), 64'(0));
        check("midrst_valid", 64'(cmd_valid), 64'(0));
        nRESET     = 1'b1;
        stat_valid = 1'b0;
        tick();

`ifdef CD_CMD_CHECKSUM_EN
        send_cmd(48'hF000_0000_0000);
        check("csum_good_count", 64'(cmd_count), 64'(1));
        send_cmd(48'h0000_0000_0000);
        check("csum_bad_cnt", 64'(cmd_bad_cnt), 64'(1));
        check("csum_bad_count", 64'(cmd_count), 64'(1));
        check("csum_bad_head", 64'(cmd_data), 64'(48'hF000_0000_0000));
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
`endif

        // Randomized traffic; ready pressure alternates by phase to reach full and empty.
        for (int n = 0; n < 4000; n++) begin
            logic [47:0] p;
            p = 48'({$urandom(), $urandom()});
            if ($urandom_range(1, 0) == 1) p = fix(p);
            if ($urandom_range(2, 0) == 0) hps_cmd_in = {~hps_cmd_in[48], p};
            else hps_cmd_in = {hps_cmd_in[48], p};
            if (((n / 300) % 2) == 0) cmd_ready = ($urandom_range(3, 0) == 0);
            else cmd_ready = ($urandom_range(3, 0) != 0);
            stat_valid = ($urandom_range(3, 0) == 0);
            stat_data  = 48'({$urandom(), $urandom()});
            nRESET     = ($urandom_range(399, 0) != 0);
            tick();
        end
        nRESET     = 1'b1;
        cmd_ready  = 1'b0;
        stat_valid = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
